// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle: pipeline status in (driven by the master/pipeline side)
// and stage-register controls plus status counters out (driven by the slave/controller).
interface pipe_hazard_if #(
  parameter int REG_ADDR = 4
);
  logic [REG_ADDR-1:0] id_rs1;
  logic [REG_ADDR-1:0] id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic [REG_ADDR-1:0] exe_rd;
  logic                exe_load;
  logic                branch_taken;
  logic                mem_access;
  logic                mem_ready;
  logic                pc_en;
  logic                ifid_stop;
  logic                ifid_flush;
  logic                idexe_hold;
  logic                idexe_bubble;
  logic                exemem_hold;
  logic                mem_err;
  logic [15:0]         stall_cnt;
  logic [15:0]         flush_cnt;
  logic [1:0]          state;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, exe_rd, exe_load,
           branch_taken, mem_access, mem_ready,
    input  pc_en, ifid_stop, ifid_flush, idexe_hold, idexe_bubble,
           exemem_hold, mem_err, stall_cnt, flush_cnt, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, exe_rd, exe_load,
           branch_taken, mem_access, mem_ready,
    output pc_en, ifid_stop, ifid_flush, idexe_hold, idexe_bubble,
           exemem_hold, mem_err, stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 4-stage core: load-use stalls, branch
// squashing and data-memory wait freezes, with saturating stall/flush statistics.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR     = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input logic         clk,
  input logic         rst,
  pipe_hazard_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  state_t      cur_state, next_state;
  logic [2:0]  flush_ctr, flush_ctr_nxt;
  logic [7:0]  wait_ctr, wait_ctr_nxt;
  logic        mem_err_q;
  logic [15:0] stall_cnt_q, flush_cnt_q;

  logic lu, mw, timeout;
  logic stall_inc, flush_inc, err_set;
  logic pc_en, ifid_stop, ifid_flush, idexe_hold, idexe_bubble, exemem_hold;

  assign lu = bus.exe_load &&
              ((bus.id_use_rs1 && (bus.id_rs1 == bus.exe_rd)) ||
               (bus.id_use_rs2 && (bus.id_rs2 == bus.exe_rd)));
  assign mw      = bus.mem_access && !bus.mem_ready;
  assign timeout = (wait_ctr == WAIT_LIMIT);

  // The flush counter stays frozen (non-zero) across a wait entered from FLUSH,
  // so it doubles as the record of which state to resume after the wait.
  always_comb begin
    next_state    = cur_state;
    flush_ctr_nxt = flush_ctr;
    wait_ctr_nxt  = wait_ctr;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    err_set       = 1'b0;
    pc_en         = 1'b1;
    ifid_stop     = 1'b0;
    ifid_flush    = 1'b0;
    idexe_hold    = 1'b0;
    idexe_bubble  = 1'b0;
    exemem_hold   = 1'b0;

    unique case (cur_state)
      RUN, FLUSH: begin
        if (mw) begin
          pc_en        = 1'b0;
          ifid_stop    = 1'b1;
          idexe_hold   = 1'b1;
          exemem_hold  = 1'b1;
          next_state   = MEM_WAIT;
          wait_ctr_nxt = 8'd1;
          stall_inc    = 1'b1;
        end else if (bus.branch_taken) begin
          ifid_flush   = 1'b1;
          idexe_bubble = 1'b1;
          flush_inc    = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            next_state    = FLUSH;
            flush_ctr_nxt = 3'd1;
          end else begin
            next_state    = RUN;
            flush_ctr_nxt = 3'd0;
          end
        end else if (cur_state == FLUSH) begin
          ifid_flush = 1'b1;
          if (flush_ctr == FLUSH_LAST) begin
            next_state    = RUN;
            flush_ctr_nxt = 3'd0;
          end else begin
            flush_ctr_nxt = flush_ctr + 3'd1;
          end
        end else if (lu) begin
          pc_en        = 1'b0;
          ifid_stop    = 1'b1;
          idexe_bubble = 1'b1;
          stall_inc    = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (mw && !timeout) begin
          pc_en        = 1'b0;
          ifid_stop    = 1'b1;
          idexe_hold   = 1'b1;
          exemem_hold  = 1'b1;
          wait_ctr_nxt = wait_ctr + 8'd1;
          stall_inc    = 1'b1;
        end else begin
          // Release cycle: still-pending mw here can only mean a timeout.
          err_set      = mw;
          wait_ctr_nxt = 8'd0;
          next_state   = (flush_ctr != 3'd0) ? FLUSH : RUN;
          if (bus.branch_taken) begin
            ifid_flush   = 1'b1;
            idexe_bubble = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              next_state    = FLUSH;
              flush_ctr_nxt = 3'd1;
            end else begin
              next_state    = RUN;
              flush_ctr_nxt = 3'd0;
            end
          end else if (lu) begin
            pc_en        = 1'b0;
            ifid_stop    = 1'b1;
            idexe_bubble = 1'b1;
            stall_inc    = 1'b1;
          end
        end
      end

      default: begin
        next_state    = RUN;
        flush_ctr_nxt = 3'd0;
        wait_ctr_nxt  = 8'd0;
      end
    endcase

    if (!rst) begin
      pc_en        = 1'b0;
      ifid_stop    = 1'b0;
      ifid_flush   = 1'b1;
      idexe_hold   = 1'b0;
      idexe_bubble = 1'b1;
      exemem_hold  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state   <= RUN;
      flush_ctr   <= 3'd0;
      wait_ctr    <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      cur_state <= next_state;
      flush_ctr <= flush_ctr_nxt;
      wait_ctr  <= wait_ctr_nxt;
      if (err_set)
        mem_err_q <= 1'b1;
      if (stall_inc && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_inc && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_stop    = ifid_stop;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idexe_hold   = idexe_hold;
  assign bus.idexe_bubble = idexe_bubble;
  assign bus.exemem_hold  = exemem_hold;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
  assign bus.state        = cur_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=8).
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_hazard_if #(.REG_ADDR(4)) bus ();

  pipe_hazard_ctrl #(
    .REG_ADDR(4),
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive every pipeline input, then let the combinational outputs settle.
  task automatic applyStimulus(input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic use1, input logic use2,
                               input logic [3:0] rd, input logic load,
                               input logic br, input logic acc, input logic rdy);
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_use_rs1   = use1;
    bus.id_use_rs2   = use2;
    bus.exe_rd       = rd;
    bus.exe_load     = load;
    bus.branch_taken = br;
    bus.mem_access   = acc;
    bus.mem_ready    = rdy;
    #1;
  endtask

  task automatic idle();
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle();

    // Reset held for three cycles.
    repeat (3) step();
    checkOutput("rst_pc_en", bus.pc_en, 0);
    checkOutput("rst_ifid_flush", bus.ifid_flush, 1);
    checkOutput("rst_idexe_bubble", bus.idexe_bubble, 1);
    checkOutput("rst_state", bus.state, 0);
    checkOutput("rst_stall_cnt", bus.stall_cnt, 0);
    checkOutput("rst_flush_cnt", bus.flush_cnt, 0);
    checkOutput("rst_mem_err", bus.mem_err, 0);
    rst = 1'b1;
    #1;
    checkOutput("post_rst_pc_en", bus.pc_en, 1);
    checkOutput("post_rst_ifid_flush", bus.ifid_flush, 0);
    step();

    // Load-use on rs1.
    applyStimulus(4'h3, 4'h0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("lu_pc_en", bus.pc_en, 0);
    checkOutput("lu_ifid_stop", bus.ifid_stop, 1);
    checkOutput("lu_idexe_bubble", bus.idexe_bubble, 1);
    checkOutput("lu_idexe_hold", bus.idexe_hold, 0);
    step();
    idle();
    checkOutput("lu_after_pc_en", bus.pc_en, 1);
    checkOutput("lu_stall_cnt", bus.stall_cnt, 1);
    // Matching register but rs1 not read.
    applyStimulus(4'h3, 4'h0, 1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("nolu_pc_en", bus.pc_en, 1);
    checkOutput("nolu_ifid_stop", bus.ifid_stop, 0);
    step();
    // Load-use through rs2.
    applyStimulus(4'h5, 4'h3, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("lu_rs2_pc_en", bus.pc_en, 0);
    step();
    // Same operands but EXE is not a load.
    applyStimulus(4'h3, 4'h3, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("noload_pc_en", bus.pc_en, 1);
    step();
    idle();
    checkOutput("lu_stall_cnt2", bus.stall_cnt, 2);

    // Taken branch: two squashed fetch cycles.
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("br0_ifid_flush", bus.ifid_flush, 1);
    checkOutput("br0_idexe_bubble", bus.idexe_bubble, 1);
    checkOutput("br0_pc_en", bus.pc_en, 1);
    step();
    idle();
    checkOutput("br1_state", bus.state, 1);
    checkOutput("br1_ifid_flush", bus.ifid_flush, 1);
    checkOutput("br1_idexe_bubble", bus.idexe_bubble, 0);
    step();
    checkOutput("br2_state", bus.state, 0);
    checkOutput("br2_ifid_flush", bus.ifid_flush, 0);
    checkOutput("br2_flush_cnt", bus.flush_cnt, 1);

    // Four wait cycles, released by mem_ready on the fifth.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("mw_pc_en", bus.pc_en, 0);
      checkOutput("mw_exemem_hold", bus.exemem_hold, 1);
      step();
    end
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mw_rel_state", bus.state, 2);
    checkOutput("mw_rel_pc_en", bus.pc_en, 1);
    checkOutput("mw_rel_exemem_hold", bus.exemem_hold, 0);
    checkOutput("mw_rel_ifid_stop", bus.ifid_stop, 0);
    checkOutput("mw_stall_cnt", bus.stall_cnt, 6);
    step();
    idle();
    checkOutput("mw_after_state", bus.state, 0);

    // Branch held through a wait is only serviced in the release cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("mwbr_ifid_flush", bus.ifid_flush, 0);
      checkOutput("mwbr_idexe_hold", bus.idexe_hold, 1);
      step();
    end
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("mwbr_rel_ifid_flush", bus.ifid_flush, 1);
    checkOutput("mwbr_rel_idexe_bubble", bus.idexe_bubble, 1);
    checkOutput("mwbr_rel_pc_en", bus.pc_en, 1);
    step();
    idle();
    checkOutput("mwbr_flush_state", bus.state, 1);
    checkOutput("mwbr_flush_cnt", bus.flush_cnt, 2);
    checkOutput("mwbr_stall_cnt", bus.stall_cnt, 10);
    step();
    checkOutput("mwbr_run_state", bus.state, 0);

    // Wait entered from FLUSH resumes FLUSH afterwards.
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("flmw_ifid_flush", bus.ifid_flush, 0);
    checkOutput("flmw_pc_en", bus.pc_en, 0);
    step();
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("flmw_wait_state", bus.state, 2);
    checkOutput("flmw_rel_ifid_flush", bus.ifid_flush, 0);
    step();
    idle();
    checkOutput("flmw_resume_state", bus.state, 1);
    checkOutput("flmw_resume_ifid_flush", bus.ifid_flush, 1);
    step();
    checkOutput("flmw_end_state", bus.state, 0);
    checkOutput("flmw_stall_cnt", bus.stall_cnt, 11);
    checkOutput("flmw_flush_cnt", bus.flush_cnt, 3);

    // Timeout: eight frozen cycles, forced release on the ninth.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("to_exemem_hold", bus.exemem_hold, 1);
      step();
    end
    checkOutput("to_rel_pc_en", bus.pc_en, 1);
    checkOutput("to_rel_exemem_hold", bus.exemem_hold, 0);
    checkOutput("to_rel_mem_err", bus.mem_err, 0);
    step();
    idle();
    checkOutput("to_mem_err", bus.mem_err, 1);
    checkOutput("to_state", bus.state, 0);
    checkOutput("to_stall_cnt", bus.stall_cnt, 19);
    repeat (5) step();
    checkOutput("to_mem_err_sticky", bus.mem_err, 1);

    // Saturation of stall_cnt through a long load-use run.
    applyStimulus(4'h3, 4'h0, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("sat_pc_en", bus.pc_en, 0);
    checkOutput("sat_stall_cnt", bus.stall_cnt, 32'h0000_FFFF);
    idle();

    // Reset asserted in the middle of a wait.
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    checkOutput("rmw_state", bus.state, 2);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rmw_rst_state", bus.state, 0);
    checkOutput("rmw_rst_stall_cnt", bus.stall_cnt, 0);
    checkOutput("rmw_rst_flush_cnt", bus.flush_cnt, 0);
    checkOutput("rmw_rst_mem_err", bus.mem_err, 0);
    checkOutput("rmw_rst_pc_en", bus.pc_en, 0);
    step();
    idle();
    rst = 1'b1;
    #1;
    checkOutput("rmw_after_pc_en", bus.pc_en, 1);
    step();
    checkOutput("rmw_after_state", bus.state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 16-bit four-stage core (IF, ID, EXE, MEM). It generates PC enable, stall (hold), flush and bubble controls for the IF/ID, ID/EXE and EXE/MEM pipeline registers. It resolves load-use hazards, branch redirects and multi-cycle data-memory waits. It also maintains a saturating stall/flush counter pair and a sticky memory-timeout flag.

## Interface
Parameters:
- REG_ADDR, 4, register index width
- FLUSH_CYCLES, 2, total cycles IF/ID is squashed after a taken branch (1..7; accounts for 1-cycle instruction ROM latency)
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before forced release (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  REG_ADDR  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the ID instruction reads rs1 / rs2
- exe_rd  in  REG_ADDR  destination register of the instruction in EXE
- exe_load  in  1  the EXE instruction is a memory read (rd_mem_en in EXE)
- branch_taken  in  1  branch resolved taken in EXE
- mem_access  in  1  the MEM instruction reads or writes data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC update enable
- ifid_stop  out  1  hold the IF/ID register
- ifid_flush  out  1  load a NOP into IF/ID
- idexe_hold  out  1  hold the ID/EXE register
- idexe_bubble  out  1  load a NOP (all enables 0) into ID/EXE
- exemem_hold  out  1  hold the EXE/MEM register
- mem_err  out  1  sticky; set when a memory timeout occurs
- stall_cnt  out  16  saturating count of stall cycles
- flush_cnt  out  16  saturating count of taken-branch redirects
- state  out  2  RUN=0, FLUSH=1, MEM_WAIT=2

## Operation
- Registered state: FSM state, 3-bit flush counter, 8-bit wait counter, mem_err, stall_cnt, flush_cnt. Control outputs are combinational from the state and current inputs, so a hazard acts in the cycle it is detected.
- Default (no condition active): pc_en=1; all hold, flush and bubble outputs = 0.
- Load-use hazard (lu): exe_load and ((id_use_rs1 and id_rs1==exe_rd) or (id_use_rs2 and id_rs2==exe_rd)).
- Memory wait (mw): mem_access and not mem_ready.
- Priority per cycle: mw > branch_taken > lu > none.
- RUN:
  - mw: pc_en=0, ifid_stop=1, idexe_hold=1, exemem_hold=1. Next state MEM_WAIT with wait counter=1. stall_cnt+1.
  - branch_taken: ifid_flush=1, idexe_bubble=1; pc_en=1 so the PC loads the target. If FLUSH_CYCLES>1, go to FLUSH with flush counter=1; otherwise stay in RUN. flush_cnt+1.
  - lu: pc_en=0, ifid_stop=1, idexe_bubble=1. Stay in RUN. stall_cnt+1.
- FLUSH: ifid_flush=1, pc_en=1.
  - Increment the flush counter each cycle. Return to RUN in the cycle the counter reaches FLUSH_CYCLES-1.
  - mw in FLUSH takes priority: same outputs as mw in RUN, ifid_flush forced to 0, flush counter frozen. Return to FLUSH when mw clears.
  - A new branch_taken in FLUSH restarts the counter at 1 and increments flush_cnt.
- MEM_WAIT: full freeze, same outputs as mw. stall_cnt+1 each cycle.
  - mem_ready=1: release this cycle with default outputs. Next state is the pre-wait state (RUN or FLUSH).
  - Wait counter reaching MEM_TIMEOUT: set mem_err and force release as if mem_ready=1.
  - Any other pending condition (branch_taken, lu) is serviced in the release cycle under the normal priority rule.
- Counters saturate at 16'hFFFF; they never wrap.
- mem_err clears only on reset.

## Timing
- Reset (rst=0, any time, asynchronous): state=RUN, all counters=0, mem_err=0.
  - Control outputs while rst=0: pc_en=0, ifid_flush=1, idexe_bubble=1, all holds=0.
  - The first cycle after release runs with default RUN behaviour.
  - Reset during MEM_WAIT or FLUSH aborts the operation with no residual state.
- Zero-cycle decision latency: outputs settle combinationally within the cycle of the triggering input.
- State and counter updates occur on the following rising clk edge.
- A load-use stall lasts exactly 1 cycle, because the load leaves EXE and the hazard term drops.
- A taken-branch penalty is FLUSH_CYCLES cycles of squashed fetch.
- MEM_WAIT length is min(cycles until mem_ready, MEM_TIMEOUT).

## Test plan
- Reset: hold rst=0 for 3 cycles, then release -> pc_en=0 during reset and 1 afterwards; state=0; stall_cnt=flush_cnt=0; mem_err=0.
- Load-use: exe_load=1, exe_rd=4'h3, id_use_rs1=1, id_rs1=4'h3 for 1 cycle -> pc_en=0, ifid_stop=1, idexe_bubble=1 in that cycle only; stall_cnt=1. With id_use_rs1=0 -> no stall.
- Branch: pulse branch_taken with FLUSH_CYCLES=2 -> cycle 0: ifid_flush=1, idexe_bubble=1; cycle 1: ifid_flush=1, state=1; cycle 2: default RUN; flush_cnt=1.
- Memory wait: mem_access=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> all holds=1 and pc_en=0 for 4 cycles, release in cycle 5, stall_cnt=4. Assert branch_taken simultaneously -> branch serviced only in the release cycle.
- Timeout: mem_access=1 and mem_ready=0 indefinitely, MEM_TIMEOUT=8 -> forced release after 8 cycles; mem_err=1 and stays 1 until rst=0.
- Saturation and reset mid-wait: preload via 65540 lu cycles -> stall_cnt=16'hFFFF. Assert rst=0 during MEM_WAIT -> immediate state=0, counters 0.
